// File: rtl/scanner_pkg.sv
// scanner_pkg: FSM state encodings and default bus widths shared between
// the front-panel sequencer and the control unit.
`default_nettype none

package scanner_pkg;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RUN     = 2'd1;
   localparam logic [1:0] INSPECT = 2'd2;

   localparam int DEFAULT_ADDR_W = 10;
   localparam int DEFAULT_DATA_W = 32;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-sample debouncer and press pulse
// for one raw push-button.
`default_nettype none

module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic fast_clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             level;
   logic             level_q;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1  <= 1'b0;
         sync_2  <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_1  <= btn;
         sync_2  <= sync_1;
         level_q <= level;
         if (sync_2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // This sample is the DEBOUNCE_CYCLES-th consecutive disagreement.
            level <= sync_2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign pulse = level & ~level_q;

endmodule

`default_nettype wire

// File: rtl/infer_scanner.sv
// infer_scanner: push-button sequencer that runs the processor, then steps
// through data memory and latches each word once its read has settled.
`default_nettype none

module infer_scanner
   import scanner_pkg::*;
#(
   parameter int ADDR_W          = DEFAULT_ADDR_W,
   parameter int DATA_W          = DEFAULT_DATA_W,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SETTLE          = 2
) (
   input  logic              fast_clk,
   input  logic              rst_n,
   input  logic              btn_run,
   input  logic              btn_next,
   input  logic              btn_prev,
   input  logic              done_i,
   input  logic [DATA_W-1:0] infer_data,
   output logic              top_en,
   output logic              infer,
   output logic [ADDR_W-1:0] infer_addr,
   output logic [DATA_W-1:0] shown_data,
   output logic              shown_valid
);

   localparam int SETTLE_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE);

   logic                run_pulse;
   logic                next_pulse;
   logic                prev_pulse;
   logic                step_fwd;
   logic                step_back;
   logic                addr_change;
   logic [1:0]          state;
   logic [ADDR_W-1:0]   addr;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [DATA_W-1:0]   data_q;
   logic                valid_q;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
      .fast_clk (fast_clk),
      .rst_n    (rst_n),
      .btn      (btn_run),
      .pulse    (run_pulse)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
      .fast_clk (fast_clk),
      .rst_n    (rst_n),
      .btn      (btn_next),
      .pulse    (next_pulse)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
      .fast_clk (fast_clk),
      .rst_n    (rst_n),
      .btn      (btn_prev),
      .pulse    (prev_pulse)
   );

   // Coincident next/prev presses cancel each other out.
   always_comb begin
      step_fwd    = next_pulse & ~prev_pulse;
      step_back   = prev_pulse & ~next_pulse;
      addr_change = (state == INSPECT) && (step_fwd || step_back);
   end

   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr       <= '0;
         settle_cnt <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (run_pulse) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (done_i) begin
                  state      <= INSPECT;
                  settle_cnt <= SETTLE_LOAD;
                  valid_q    <= 1'b0;
               end
            end
            INSPECT: begin
               if (addr_change) begin
                  addr       <= step_fwd ? addr + 1'b1 : addr - 1'b1;
                  settle_cnt <= SETTLE_LOAD;
                  valid_q    <= 1'b0;
               end else if (!valid_q) begin
                  // A clear valid flag means a settle is still in progress.
                  if (settle_cnt == '0) begin
                     data_q  <= infer_data;
                     valid_q <= 1'b1;
                  end else begin
                     settle_cnt <= settle_cnt - 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign top_en      = (state == RUN);
   assign infer       = (state == INSPECT);
   assign infer_addr  = addr;
   assign shown_data  = data_q;
   assign shown_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_infer_scanner.sv
// tb_infer_scanner: directed scenario checks for infer_scanner with memory
// modelled as data = address * 3.
`default_nettype none

module tb_infer_scanner;

   logic        fast_clk;
   logic        rst_n;
   logic        btn_run;
   logic        btn_next;
   logic        btn_prev;
   logic        done_i;
   logic [31:0] infer_data;
   logic        top_en;
   logic        infer;
   logic [9:0]  infer_addr;
   logic [31:0] shown_data;
   logic        shown_valid;

   int checks = 0;
   int errors = 0;

   infer_scanner #(
      .ADDR_W          (10),
      .DATA_W          (32),
      .DEBOUNCE_CYCLES (4),
      .SETTLE          (2)
   ) dut (
      .fast_clk    (fast_clk),
      .rst_n       (rst_n),
      .btn_run     (btn_run),
      .btn_next    (btn_next),
      .btn_prev    (btn_prev),
      .done_i      (done_i),
      .infer_data  (infer_data),
      .top_en      (top_en),
      .infer       (infer),
      .infer_addr  (infer_addr),
      .shown_data  (shown_data),
      .shown_valid (shown_valid)
   );

   assign infer_data = 32'(infer_addr) * 32'd3;

   initial fast_clk = 1'b0;
   always #5 fast_clk = ~fast_clk;

   task automatic tick();
      @(posedge fast_clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Full press of next: long enough to debounce, then released and settled.
   task automatic press_next();
      btn_next = 1'b1;
      ticks(8);
      btn_next = 1'b0;
      ticks(12);
   endtask

   task automatic test_reset();
      ticks(5);
      checks++; if (top_en !== 1'b0) begin errors++; $display("FAIL reset_top_en got %0b want 0", top_en); end
      checks++; if (infer !== 1'b0) begin errors++; $display("FAIL reset_infer got %0b want 0", infer); end
      checks++; if (infer_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", infer_addr); end
      checks++; if (shown_data !== 32'd0) begin errors++; $display("FAIL reset_data got %0d want 0", shown_data); end
      checks++; if (shown_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", shown_valid); end
      rst_n = 1'b1;
      tick();
      checks++; if (top_en !== 1'b0) begin errors++; $display("FAIL release_top_en got %0b want 0", top_en); end
      btn_run  = 1'b0;
      btn_next = 1'b0;
      btn_prev = 1'b0;
      ticks(20);
      checks++; if (top_en !== 1'b0 || infer !== 1'b0) begin errors++; $display("FAIL release_idle got top_en=%0b infer=%0b want 0/0", top_en, infer); end
   endtask

   task automatic test_idle_ignore();
      press_next();
      done_i = 1'b1;
      ticks(5);
      done_i = 1'b0;
      tick();
      checks++; if (infer_addr !== 10'd0) begin errors++; $display("FAIL idle_addr got %0d want 0", infer_addr); end
      checks++; if (top_en !== 1'b0 || infer !== 1'b0) begin errors++; $display("FAIL idle_state got top_en=%0b infer=%0b want 0/0", top_en, infer); end
   endtask

   task automatic test_run_flow();
      btn_run = 1'b1;
      ticks(6);
      checks++; if (top_en !== 1'b0) begin errors++; $display("FAIL run_early got %0b want 0", top_en); end
      tick();
      checks++; if (top_en !== 1'b1) begin errors++; $display("FAIL run_latency got %0b want 1", top_en); end
      ticks(3);
      btn_run = 1'b0;
      press_next();
      ticks(30);
      checks++; if (top_en !== 1'b1 || infer !== 1'b0 || infer_addr !== 10'd0) begin
         errors++; $display("FAIL run_hold got top_en=%0b infer=%0b addr=%0d want 1/0/0", top_en, infer, infer_addr);
      end
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      checks++; if (infer !== 1'b1 || top_en !== 1'b0) begin errors++; $display("FAIL done_switch got infer=%0b top_en=%0b want 1/0", infer, top_en); end
      checks++; if (shown_valid !== 1'b0) begin errors++; $display("FAIL done_valid got %0b want 0", shown_valid); end
      ticks(2);
      checks++; if (shown_valid !== 1'b0) begin errors++; $display("FAIL first_latch_early got %0b want 0", shown_valid); end
      tick();
      checks++; if (shown_valid !== 1'b1 || shown_data !== 32'd0) begin
         errors++; $display("FAIL first_latch got valid=%0b data=%0d want 1/0", shown_valid, shown_data);
      end
   endtask

   task automatic test_step_wrap();
      btn_prev = 1'b1;
      ticks(6);
      checks++; if (infer_addr !== 10'd0) begin errors++; $display("FAIL prev_early got %0d want 0", infer_addr); end
      tick();
      checks++; if (infer_addr !== 10'd1023 || shown_valid !== 1'b0) begin
         errors++; $display("FAIL prev_wrap got addr=%0d valid=%0b want 1023/0", infer_addr, shown_valid);
      end
      ticks(2);
      checks++; if (shown_valid !== 1'b0) begin errors++; $display("FAIL settle_early got %0b want 0", shown_valid); end
      tick();
      checks++; if (shown_valid !== 1'b1 || shown_data !== 32'd3069) begin
         errors++; $display("FAIL prev_latch got valid=%0b data=%0d want 1/3069", shown_valid, shown_data);
      end
      ticks(3);
      btn_prev = 1'b0;
      ticks(12);
      press_next();
      checks++; if (infer_addr !== 10'd0 || shown_data !== 32'd0 || shown_valid !== 1'b1) begin
         errors++; $display("FAIL next_wrap got addr=%0d data=%0d valid=%0b want 0/0/1", infer_addr, shown_data, shown_valid);
      end
      press_next();
      checks++; if (infer_addr !== 10'd1 || shown_data !== 32'd3 || shown_valid !== 1'b1) begin
         errors++; $display("FAIL next_one got addr=%0d data=%0d valid=%0b want 1/3/1", infer_addr, shown_data, shown_valid);
      end
   endtask

   task automatic test_bounce();
      btn_next = 1'b1;
      ticks(3);
      btn_next = 1'b0;
      ticks(15);
      checks++; if (infer_addr !== 10'd1 || shown_valid !== 1'b1) begin
         errors++; $display("FAIL glitch got addr=%0d valid=%0b want 1/1", infer_addr, shown_valid);
      end
      btn_next = 1'b1;
      ticks(6);
      btn_next = 1'b0;
      ticks(15);
      checks++; if (infer_addr !== 10'd2 || shown_data !== 32'd6 || shown_valid !== 1'b1) begin
         errors++; $display("FAIL held6 got addr=%0d data=%0d valid=%0b want 2/6/1", infer_addr, shown_data, shown_valid);
      end
   endtask

   task automatic test_simultaneous();
      logic stable;
      stable   = 1'b1;
      btn_next = 1'b1;
      btn_prev = 1'b1;
      for (int i = 0; i < 25; i++) begin
         if (i == 10) begin
            btn_next = 1'b0;
            btn_prev = 1'b0;
         end
         tick();
         if (shown_valid !== 1'b1 || infer_addr !== 10'd2) stable = 1'b0;
      end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL simultaneous got stable=%0b want 1", stable); end
      checks++; if (infer_addr !== 10'd2 || shown_data !== 32'd6) begin
         errors++; $display("FAIL simul_final got addr=%0d data=%0d want 2/6", infer_addr, shown_data);
      end
   endtask

   task automatic test_run_ignored();
      btn_run = 1'b1;
      ticks(8);
      btn_run = 1'b0;
      ticks(12);
      checks++; if (infer !== 1'b1 || top_en !== 1'b0 || infer_addr !== 10'd2) begin
         errors++; $display("FAIL run_in_inspect got infer=%0b top_en=%0b addr=%0d want 1/0/2", infer, top_en, infer_addr);
      end
   endtask

   task automatic test_reset_mid_settle();
      btn_next = 1'b1;
      ticks(7);
      checks++; if (infer_addr !== 10'd3 || shown_valid !== 1'b0) begin
         errors++; $display("FAIL pre_reset got addr=%0d valid=%0b want 3/0", infer_addr, shown_valid);
      end
      btn_next = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      checks++; if (infer_addr !== 10'd0 || shown_valid !== 1'b0 || shown_data !== 32'd0) begin
         errors++; $display("FAIL async_reset got addr=%0d valid=%0b data=%0d want 0/0/0", infer_addr, shown_valid, shown_data);
      end
      checks++; if (infer !== 1'b0 || top_en !== 1'b0) begin
         errors++; $display("FAIL async_reset_state got infer=%0b top_en=%0b want 0/0", infer, top_en);
      end
      ticks(3);
      rst_n = 1'b1;
      ticks(10);
      checks++; if (shown_valid !== 1'b0 || shown_data !== 32'd0 || infer !== 1'b0) begin
         errors++; $display("FAIL no_latch_after_reset got valid=%0b data=%0d infer=%0b want 0/0/0", shown_valid, shown_data, infer);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      btn_run  = 1'b1;
      btn_next = 1'b1;
      btn_prev = 1'b1;
      done_i   = 1'b0;
      test_reset();
      test_idle_ignore();
      test_run_flow();
      test_step_wrap();
      test_bounce();
      test_simultaneous();
      test_run_ignored();
      test_reset_mid_settle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
